// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and constants for the ALU time-share controller
package alu_share_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OP_W  = 3;
    localparam int CNT_W     = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with pointer update on grant
module rr_arb2
    import alu_share_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id
);

    logic ptr;
    logic any_valid;

    // Winner selection: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        gnt_id    = REQ0;
        any_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            gnt_id = ptr;
        end else if (valid1) begin
            gnt_id = REQ1;
        end
        gnt0 = en & any_valid & (gnt_id == REQ0);
        gnt1 = en & any_valid & (gnt_id == REQ1);
    end

    // Pointer moves to the other requester whenever a grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ0;
        end else if (gnt0 || gnt1) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - sequences two requesters onto one ALU (ALU_SHARE_CNT_EN adds grant counters)
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OP_W  = DEF_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [OP_W-1:0]  alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout,
    output logic             rsp_zero
`ifdef ALU_SHARE_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
`endif
);

    state_t state;
    state_t state_nxt;

    logic gnt0;
    logic gnt1;
    logic gnt_id;
    logic accept;
    logic owner_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state == IDLE),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .gnt_id (gnt_id)
    );

    // A grant only ever goes to a valid requester, so grant alone means accept.
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign rsp_valid  = (state == RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one accept, one execute cycle, then wait for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand hold: the ALU inputs change only when a new operation is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            owner_q <= REQ0;
        end else if (accept) begin
            owner_q <= gnt_id;
            if (gnt_id == REQ1) begin
                alu_op <= req1_op;
                alu_a  <= req1_a;
                alu_b  <= req1_b;
            end else begin
                alu_op <= req0_op;
                alu_a  <= req0_a;
                alu_b  <= req0_b;
            end
        end
    end

    // Result capture at the end of the execute cycle; held through the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id   <= REQ0;
            rsp_y    <= '0;
            rsp_cout <= 1'b0;
            rsp_zero <= 1'b1;
        end else if (state == EXEC) begin
            rsp_id   <= owner_q;
            rsp_y    <= alu_y;
            rsp_cout <= alu_cout;
            rsp_zero <= ~|alu_y;
        end
    end

`ifdef ALU_SHARE_CNT_EN
    // Per-requester accept counters, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (gnt0) gnt0_cnt <= sat_inc(gnt0_cnt);
            if (gnt1) gnt1_cnt <= sat_inc(gnt1_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_cout;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
    logic [7:0] rsp_y;
`ifdef ALU_SHARE_CNT_EN
    logic [7:0] gnt0_cnt, gnt1_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_share_ctrl dut (
`ifdef ALU_SHARE_CNT_EN
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {cout, y}.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return 9'd0;
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb {alu_cout, alu_y} = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Transaction-level model: block is either free or owns one operation.
    bit       m_busy = 0;
    int       m_age  = 0;
    bit       m_ptr  = 0;
    bit       m_own  = 0;
    bit [2:0] m_op   = 0;
    bit [7:0] m_a    = 0, m_b = 0, m_y = 0;
    bit       m_c    = 0;
    int       m_cnt0 = 0, m_cnt1 = 0;

    always @(negedge clk) begin
        bit any, win;
        any = req0_valid | req1_valid;
        win = (req0_valid & req1_valid) ? m_ptr : req1_valid;
        chk("req0_ready", req0_ready, !m_busy && any && !win);
        chk("req1_ready", req1_ready, !m_busy && any && win);
        chk("rsp_valid", rsp_valid, m_busy && m_age >= 2);
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        if (m_busy && m_age >= 2) begin
            chk("rsp_id", rsp_id, m_own);
            chk("rsp_y", rsp_y, m_y);
            chk("rsp_cout", rsp_cout, m_c);
            chk("rsp_zero", rsp_zero, m_y == 8'd0);
        end
`ifdef ALU_SHARE_CNT_EN
        chk("gnt0_cnt", gnt0_cnt, m_cnt0);
        chk("gnt1_cnt", gnt1_cnt, m_cnt1);
`endif
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_op = 0; m_a = 0; m_b = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (!m_busy) begin
            if (any) begin
                m_own  = win;
                m_op   = win ? req1_op : req0_op;
                m_a    = win ? req1_a  : req0_a;
                m_b    = win ? req1_b  : req0_b;
                {m_c, m_y} = alu_f(m_op, m_a, m_b);
                m_ptr  = !win;
                m_busy = 1;
                m_age  = 1;
                if (win) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
                else     m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            end
        end else if (m_age >= 2) begin
            if (rsp_ready) m_busy = 0;
        end else begin
            m_age++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
    endtask

    // Issue one operation from a single requester and check latency and result.
    task automatic do_op(input string name, input bit id, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ey, input logic ec);
        bit got;
        int lat;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin got = 1; break; end
        end
        chk({name, "_accept"}, got, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 1; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
            lat++;
        end
        chk({name, "_rsp_seen"}, got, 1);
        chk({name, "_latency"}, lat, 2);
        chk({name, "_id"}, rsp_id, id);
        chk({name, "_y"}, rsp_y, ey);
        chk({name, "_cout"}, rsp_cout, ec);
        chk({name, "_zero"}, rsp_zero, ey == 8'd0);
    endtask

    initial begin
        bit gq[$];
        bit rq[$];
        bit got;
        rst = 1; rsp_ready = 1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_zero", rsp_zero, 1);
        chk("reset_rsp_y", rsp_y, 0);
        chk("reset_rsp_cout", rsp_cout, 0);
        chk("reset_alu_a", alu_a, 0);

        // Single op: 5 + 3
        do_op("single", 0, 3'd0, 8'h05, 8'h03, 8'h08, 1'b0);
        drain();

        // Zero/carry on requester 1
        do_op("zc", 1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1);
        drain();

        // Other ops through the model
        do_op("xor", 0, 3'd4, 8'h5A, 8'h0F, 8'h55, 1'b0);
        do_op("clr", 1, 3'd5, 8'h12, 8'h34, 8'h00, 1'b0);
        drain();

        // Contention from reset: grants must alternate
        do_reset();
        req0_valid = 1; req0_op = 3'd0; req0_a = 8'h10; req0_b = 8'h20;
        req1_valid = 1; req1_op = 3'd2; req1_a = 8'hF0; req1_b = 8'h3C;
        for (int i = 0; i < 60 && rq.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready) gq.push_back(1'b0);
            if (req1_ready) gq.push_back(1'b1);
            if (rsp_valid && rsp_ready) rq.push_back(rsp_id);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("cont_grants", gq.size(), 4);
        chk("cont_rsps", rq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size() && i < rq.size(); i++) begin
            chk("cont_grant_order", gq[i], i % 2);
            chk("cont_rsp_order", rq[i], i % 2);
        end
        drain();

        // Backpressure: response held, no accepts while waiting
        rsp_ready = 0;
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 3'd4; req0_a = 8'h5A; req0_b = 8'hFF;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin got = 1; break; end
        end
        chk("bp_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_op = 3'd3; req1_a = 8'h01; req1_b = 8'h02;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        chk("bp_rsp_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_y", rsp_y, 8'hA5);
            chk("bp_no_ready", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_last_valid", rsp_valid, 1);
        @(negedge clk);
        chk("bp_released", rsp_valid, 0);
        chk("bp_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        drain();

        // Mid-op reset: pointer returns to requester 0
        do_reset();
        req0_valid = 1; req0_op = 3'd0; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1; req1_op = 3'd0; req1_a = 8'h02; req1_b = 8'h02;
        @(negedge clk);
        chk("mid_first_grant", req0_ready, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_grant0", req0_ready, 1);
        chk("mid_grant1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        drain();

`ifdef ALU_SHARE_CNT_EN
        begin
            int acc;
            do_reset();
            req0_valid = 1; req0_op = 3'd0; req0_a = 8'h01; req0_b = 8'h02;
            acc = 0;
            for (int i = 0; i < 1500 && acc < 300; i++) begin
                @(negedge clk);
                if (req0_ready) acc++;
            end
            @(posedge clk); #1;
            req0_valid = 0;
            chk("cnt_accepts", acc, 300);
            drain();
            chk("cnt_gnt0", gnt0_cnt, 8'd255);
            chk("cnt_gnt1", gnt1_cnt, 8'd0);
        end
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
